pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipeline. It drives the load-enable and flush (bubble-insert) controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three conditions:
- load-use hazards
- taken-branch squashes
- data-memory wait states, supervised by a timeout

It sits beside the datapath and holds no datapath state.

---
 rtl/pipeline_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls, branch squash,
// data-memory wait with timeout. Optional perf counters under `PIPE_PERF_CNT_EN`.
module pipeline_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              if_id_uses_rt,
  input  logic              id_ex_mem_read,
  input  logic [REG_AW-1:0] id_ex_rt,
  input  logic              branch_taken_EX,
  input  logic              mem_req_MEM,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              mem_wb_flush,
  output logic              bus_err,
  output logic [1:0]        state_dbg
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state;
  logic [7:0] wcnt;
  logic       load_use;
  logic       mem_stall;

  assign state_dbg = state;

  // Handshake: mem_req_MEM && mem_ready retires the access in that same cycle; mem_ready alone is ignored.
  always_comb begin
    load_use  = id_ex_mem_read && (id_ex_rt != '0) &&
                ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
    mem_stall = mem_req_MEM && !mem_ready;

    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;

    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
          end else if (branch_taken_EX) begin
            // The squashed ID instruction makes any simultaneous load-use moot.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!mem_ready) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
          end
        end
        ERROR: begin
          pc_en        = 1'b0;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          mem_wb_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      wcnt    <= 8'd0;
      bus_err <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state <= MEM_WAIT;
            wcnt  <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state <= RUN;
          end else if (wcnt == TIMEOUT) begin
            state   <= ERROR;
            bus_err <= 1'b1;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        ERROR:   bus_err <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic squash;
  logic stalled;

  assign squash  = (state == RUN) && !mem_stall && branch_taken_EX;
  assign stalled = !pc_en && ((state == RUN) || (state == MEM_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (stalled && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
      if (squash && (flush_count != 32'hFFFF_FFFF)) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios followed by random traffic,
// compared each cycle against a rule-level reference model.
module tb_pipeline_ctrl;

  localparam int AW  = 5;
  localparam int TMO = 4;
  localparam int W   = 8;

  // Control vector order: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, mem_wb_fl}
  localparam logic [W-1:0] C_RESET  = 8'b00000_111;
  localparam logic [W-1:0] C_PASS   = 8'b11111_000;
  localparam logic [W-1:0] C_FREEZE = 8'b00001_001;
  localparam logic [W-1:0] C_SQUASH = 8'b11111_110;
  localparam logic [W-1:0] C_STALL  = 8'b00111_010;
  localparam logic [W-1:0] C_DRAIN  = 8'b01111_111;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] if_id_rs = '0, if_id_rt = '0, id_ex_rt = '0;
  logic          if_id_uses_rt = 1'b0, id_ex_mem_read = 1'b0, branch_taken_EX = 1'b0;
  logic          mem_req_MEM = 1'b0, mem_ready = 1'b0;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, mem_wb_flush, bus_err;
  logic [1:0]    state_dbg;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]   stall_cycles, flush_count;
`endif

  pipeline_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .branch_taken_EX(branch_taken_EX), .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .bus_err(bus_err), .state_dbg(state_dbg)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;
  logic [W-1:0] exp_q[$];

  // Reference model state
  bit m_wait;
  int m_waited;
  bit m_err;
  int m_stalls;
  int m_flushes;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] observed();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush};
  endfunction

  function automatic bit is_load_use();
    return id_ex_mem_read && (id_ex_rt != 0) &&
           ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
  endfunction

  function automatic logic [W-1:0] model_ctrl();
    if (m_err) return C_DRAIN;
    if (m_wait) return mem_ready ? C_PASS : C_FREEZE;
    if (mem_req_MEM && !mem_ready) return C_FREEZE;
    if (branch_taken_EX) return C_SQUASH;
    if (is_load_use()) return C_STALL;
    return C_PASS;
  endfunction

  task automatic model_clear();
    m_wait = 0; m_waited = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic drive(input bit req, input bit rdy, input bit br, input bit mr,
                       input int ex_rt, input int rs, input int rt, input bit uses);
    mem_req_MEM = req; mem_ready = rdy; branch_taken_EX = br; id_ex_mem_read = mr;
    id_ex_rt = AW'(ex_rt); if_id_rs = AW'(rs); if_id_rt = AW'(rt); if_id_uses_rt = uses;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Check one cycle (inputs already driven), then advance across the edge and update the model.
  task automatic run_cycle(input string tag);
    logic [W-1:0] e;
    #2;
    e = model_ctrl();
    exp_q.push_back(e);
    check_val({tag, ".ctrl"}, 32'(observed()), 32'(exp_q.pop_front()));
    check_val({tag, ".bus_err"}, 32'(bus_err), 32'(m_err));
`ifdef PIPE_PERF_CNT_EN
    check_val({tag, ".stalls"}, stall_cycles, 32'(m_stalls));
    check_val({tag, ".flushes"}, flush_count, 32'(m_flushes));
`endif
    @(posedge clk);
    if (!m_err && !e[7]) m_stalls++;
    if (e == C_SQUASH && !m_err && !m_wait) m_flushes++;
    if (m_err) begin
      // Sticky until reset
    end else if (m_wait) begin
      if (mem_ready) m_wait = 0;
      else if (m_waited == TMO) begin m_wait = 0; m_err = 1; end
      else m_waited++;
    end else if (mem_req_MEM && !mem_ready) begin
      m_wait = 1; m_waited = 1;
    end
    #1;
  endtask

  task automatic apply_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check_val("rst.ctrl", 32'(observed()), 32'(C_RESET));
    check_val("rst.bus_err", 32'(bus_err), 32'd0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int err_run;
    model_clear();
    idle();
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // Reset release, no hazards
    idle();
    run_cycle("idle");

    // Load-use on rs: exactly one stall cycle
    drive(0, 0, 0, 1, 5, 5, 0, 0); run_cycle("lu_rs");
    idle();                        run_cycle("lu_after");
    drive(0, 0, 0, 1, 0, 0, 0, 0); run_cycle("lu_r0");
    drive(0, 0, 0, 1, 7, 3, 7, 1); run_cycle("lu_rt");
    drive(0, 0, 0, 1, 7, 3, 7, 0); run_cycle("lu_rt_unused");

    // Branch overrides load-use
    drive(0, 0, 1, 1, 5, 5, 0, 0); run_cycle("br_lu");
    idle();                        run_cycle("br_after");

    // Memory wait of 3 cycles
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0); run_cycle("mw_wait");
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0); run_cycle("mw_done");
    idle();                        run_cycle("mw_run");
    drive(0, 1, 0, 0, 0, 0, 0, 0); run_cycle("rdy_no_req");

`ifdef PIPE_PERF_CNT_EN
    apply_reset();
    drive(0, 0, 0, 1, 4, 4, 0, 0); run_cycle("perf_lu1");
    idle();                        run_cycle("perf_gap1");
    drive(0, 0, 0, 1, 9, 1, 9, 1); run_cycle("perf_lu2");
    drive(0, 0, 1, 0, 0, 0, 0, 0); run_cycle("perf_br");
    idle();                        run_cycle("perf_gap2");
    check_val("perf.stall_cycles", stall_cycles, 32'd2);
    check_val("perf.flush_count", flush_count, 32'd1);
`endif

    // Timeout into ERROR, then recovery by reset
    for (int i = 0; i < TMO + 4; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0); run_cycle("tmo");
    end
    check_val("tmo.bus_err_set", 32'(bus_err), 32'd1);
    drive(1, 1, 1, 0, 0, 0, 0, 0); run_cycle("err_ready");
    apply_reset();
    idle();
    run_cycle("post_err");

    // Random traffic
    err_run = 0;
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) < 3), ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 1) == 1), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), ($urandom_range(0, 1) == 1));
      run_cycle("rnd");
      if (m_err) err_run++;
      if (err_run > 2) begin
        apply_reset();
        err_run = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
